mem_bus_controller: RTL and testbench
=====================================

// Module: mem_bus_controller
// PURPOSE
// Parametrised CPU-side memory bus controller for the 6502 core: valid/ready request, one-cycle response.
// Decodes RAM / IO / ROM regions from base parameters; inserts per-region wait states.
// Also stretches IO cycles on an external mem_wait, with timeout.
// Write protection on ROM; the registered read data stays stable in the response cycle.
// PARAMETERS
// ADDR_W       16       address width (bits)
// DATA_W       8        data width (bits)
// IO_BASE      'h8000   first IO address; RAM is [0, IO_BASE)
// ROM_BASE     'hC000   first ROM address; ROM is [ROM_BASE, 2^ADDR_W)
// RAM_WAIT     0        extra access cycles for RAM
// IO_WAIT      2        extra access cycles for IO (minimum before mem_wait is honoured)
// ROM_WAIT     1        extra access cycles for ROM
// WAIT_TIMEOUT 15       max extra cycles an IO access may be held by mem_wait before error
// PORTS
// clk        in   1       clock, all flops on rising edge
// rst        in   1       asynchronous, active-high reset
// req_valid  in   1       request present
// req_write  in   1       1=write, 0=read
// req_addr   in   ADDR_W  request address
// req_wdata  in   DATA_W  write data
// req_ready  out  1       controller can accept a request this cycle
// rsp_valid  out  1       one-cycle response pulse
// rsp_rdata  out  DATA_W  read data (0 for writes or errors)
// rsp_err    out  1       ROM write or IO timeout; valid with rsp_valid
// ram_cs     out  1       RAM select, asserted only during the access phase
// io_cs      out  1       IO select, asserted only during the access phase
// rom_cs     out  1       ROM select, asserted only during the access phase
// mem_addr   out  ADDR_W  latched address during access, else 0
// mem_wdata  out  DATA_W  latched write data during write access, else 0
// mem_rdata  in   DATA_W  external read data
// mem_oe     out  1       read strobe, held for the whole read access
// mem_we     out  1       write strobe, held for the whole write access
// mem_wait   in   1       external stretch; honoured only while io_cs=1
// BEHAVIOUR
// - Reset (async): state=IDLE, counters=0.
//   All outputs are 0 while rst=1, including req_ready.
//   req_ready=1 from the first cycle after rst is released.
// - req_ready = (state==IDLE). Accept on req_valid&&req_ready.
//   On accept, latch addr, wdata, write and region.
// - States:
//   IDLE->ACCESS on accept.
//   IDLE->RESP on accept if write to ROM; rsp_err=1, no strobe or cs ever asserted.
//   ACCESS: cs/oe/we driven. Wait counter loaded with the region WAIT; 1+WAIT cycles minimum.
//   ACCESS->RESP when counter==0, and not (io && mem_wait).
//   Once IO_WAIT is exhausted, mem_wait holds ACCESS.
//   More than WAIT_TIMEOUT extra held cycles -> RESP with rsp_err=1 and rsp_rdata=0.
//   RESP: rsp_valid=1 for exactly 1 cycle, then IDLE.
// - mem_rdata is sampled into the rsp_rdata register on the clock edge ending the final ACCESS cycle.
//   rsp_rdata holds that value until the next response.
// - Latency, accept edge to rsp_valid: 2+WAIT cycles.
//   Throughput: one access per 3+WAIT cycles. No back-to-back overlap.
// - Region compare is unsigned, full ADDR_W.
//   Addresses IO_BASE-1, ROM_BASE-1 and all-ones map to RAM, IO and ROM respectively.
// - req_* changes after accept are ignored. A second request waits for req_ready.
// - rst mid-access aborts immediately: strobes drop asynchronously and no rsp_valid is issued.
// STRUCTURE
// - Shared package mem_bus_pkg: region_e {REG_RAM, REG_IO, REG_ROM}; state_e {IDLE, ACCESS, RESP}.
//   Default base constants also live in the package.
// - Sub-module mem_region_decode: combinational addr -> region_e, parametrised by IO_BASE and ROM_BASE.
// - Wait/timeout counter width: $clog2(max(IO_WAIT+WAIT_TIMEOUT, RAM_WAIT, ROM_WAIT)+1).
// TESTING
// 1. RAM read at 'h1234, mem_rdata='hA5 -> ram_cs/mem_oe for 1 cycle; rsp_valid 2 cycles after accept; rdata='hA5, err=0.
// 2. RAM write at 'h7FFF, wdata='h3C -> mem_we=1 and mem_wdata='h3C for 1 cycle; ram_cs=1; rsp err=0.
// 3. ROM read at 'hFFFC -> rom_cs/oe for 2 cycles; rsp at 3 cycles. ROM write at 'hC000 -> no we, rsp_err=1 next cycle.
// 4. IO read at 'h8000, mem_wait high 5 cycles -> access 3+3 cycles; correct rdata. Hold mem_wait 20 cycles -> rsp_err=1, rdata=0.
// 5. Assert rst during an IO access -> strobes/cs go 0 same cycle; no rsp_valid. After release, req_ready=1 and a RAM read completes.
// 6. Boundaries 'h7FFF/'h8000/'hBFFF/'hC000 -> RAM/IO/IO/ROM selects. req_valid held high -> exactly one accept per 3+WAIT cycles.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the 6502 memory bus controller.
// Region/state enums, default address map and a small max helper.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO,
        REG_ROM
    } region_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam int          DEF_ADDR_W   = 16;
    localparam int          DEF_DATA_W   = 8;
    localparam int unsigned DEF_IO_BASE  = 'h8000;
    localparam int unsigned DEF_ROM_BASE = 'hC000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/mem_bus_if.sv
// CPU request/response and external memory bus bundle.
// master: CPU + memory side; slave: the controller.
interface mem_bus_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              ram_cs;
    logic              io_cs;
    logic              rom_cs;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_oe;
    logic              mem_we;
    logic              mem_wait;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output mem_rdata, mem_wait,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ram_cs, io_cs, rom_cs, mem_addr, mem_wdata,
        input  mem_oe, mem_we
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  mem_rdata, mem_wait,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ram_cs, io_cs, rom_cs, mem_addr, mem_wdata,
        output mem_oe, mem_we
    );

endinterface

// File: rtl/mem_region_decode.sv
// Combinational address -> region decode (RAM / IO / ROM).
// Ports: addr in, region out. Unsigned full-width compares.
module mem_region_decode
    import mem_bus_pkg::*;
#(
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int unsigned IO_BASE  = DEF_IO_BASE,
    parameter int unsigned ROM_BASE = DEF_ROM_BASE
) (
    input  logic [ADDR_W-1:0] addr,
    output region_e           region
);

    localparam logic [ADDR_W-1:0] IO_B  = ADDR_W'(IO_BASE);
    localparam logic [ADDR_W-1:0] ROM_B = ADDR_W'(ROM_BASE);

    always_comb begin
        region = REG_RAM;
        unique case (1'b1)
            (addr >= ROM_B):                  region = REG_ROM;
            (addr >= IO_B) && (addr < ROM_B): region = REG_IO;
            (addr < IO_B):                    region = REG_RAM;
            default:                          region = REG_RAM;
        endcase
    end

endmodule

// File: rtl/mem_bus_controller.sv
// CPU-side memory bus controller: valid/ready request, region wait
// states, IO stretch with timeout, ROM write protect. Ports: clk, rst, bus.
module mem_bus_controller
    import mem_bus_pkg::*;
#(
    parameter int          ADDR_W       = DEF_ADDR_W,
    parameter int          DATA_W       = DEF_DATA_W,
    parameter int unsigned IO_BASE      = DEF_IO_BASE,
    parameter int unsigned ROM_BASE     = DEF_ROM_BASE,
    parameter int          RAM_WAIT     = 0,
    parameter int          IO_WAIT      = 2,
    parameter int          ROM_WAIT     = 1,
    parameter int          WAIT_TIMEOUT = 15
) (
    input  logic      clk,
    input  logic      rst,
    mem_bus_if.slave  bus
);

    localparam int CMAX = max3(IO_WAIT + WAIT_TIMEOUT, RAM_WAIT, ROM_WAIT);
    localparam int CW   = (CMAX < 1) ? 1 : $clog2(CMAX + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(IO_WAIT + WAIT_TIMEOUT);

    state_e            state;
    region_e           dec_region;
    region_e           region_q;
    logic              write_q;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     lim_q;
    logic [CW-1:0]     dec_lim;
    logic              acc_done;
    logic              acc_err;

    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              ram_cs_q;
    logic              io_cs_q;
    logic              rom_cs_q;
    logic              oe_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    mem_region_decode #(
        .ADDR_W   (ADDR_W),
        .IO_BASE  (IO_BASE),
        .ROM_BASE (ROM_BASE)
    ) u_dec (
        .addr   (bus.req_addr),
        .region (dec_region)
    );

    always_comb begin
        dec_lim = CW'(RAM_WAIT);
        unique case (dec_region)
            REG_IO:  dec_lim = CW'(IO_WAIT);
            REG_ROM: dec_lim = CW'(ROM_WAIT);
            default: dec_lim = CW'(RAM_WAIT);
        endcase
    end

    // cnt counts access cycles past the first; beyond lim_q it
    // counts cycles held by mem_wait (IO only).
    always_comb begin
        acc_done = 1'b0;
        acc_err  = 1'b0;
        if (cnt >= lim_q) begin
            if (region_q == REG_IO && bus.mem_wait) begin
                if (cnt == HOLD_MAX) begin
                    acc_done = 1'b1;
                    acc_err  = 1'b1;
                end
            end else begin
                acc_done = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            region_q    <= REG_RAM;
            write_q     <= 1'b0;
            cnt         <= '0;
            lim_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            ram_cs_q    <= 1'b0;
            io_cs_q     <= 1'b0;
            rom_cs_q    <= 1'b0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        region_q <= dec_region;
                        write_q  <= bus.req_write;
                        cnt      <= '0;
                        lim_q    <= dec_lim;
                        if (bus.req_write && dec_region == REG_ROM) begin
                            // Protected: answer at once, never touch the bus.
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state    <= ACCESS;
                            ram_cs_q <= (dec_region == REG_RAM);
                            io_cs_q  <= (dec_region == REG_IO);
                            rom_cs_q <= (dec_region == REG_ROM);
                            oe_q     <= !bus.req_write;
                            we_q     <= bus.req_write;
                            addr_q   <= bus.req_addr;
                            wdata_q  <= bus.req_write ? bus.req_wdata : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (acc_done) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= acc_err;
                        rsp_rdata_q <= (acc_err || write_q) ? '0 : bus.mem_rdata;
                        ram_cs_q    <= 1'b0;
                        io_cs_q     <= 1'b0;
                        rom_cs_q    <= 1'b0;
                        oe_q        <= 1'b0;
                        we_q        <= 1'b0;
                        addr_q      <= '0;
                        wdata_q     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst so ready reads 0 throughout reset.
    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.ram_cs    = ram_cs_q;
    assign bus.io_cs     = io_cs_q;
    assign bus.rom_cs    = rom_cs_q;
    assign bus.mem_oe    = oe_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Directed-vector bench for mem_bus_controller.
// Drives/samples on the falling edge; one check task for all compares.
module tb_mem_bus_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_if #(.ADDR_W(16), .DATA_W(8)) bus();

    mem_bus_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    int         r_lat, r_ram, r_io, r_rom, r_oe, r_we;
    logic       r_err;
    logic [7:0] r_rdata, r_wd;
    logic [15:0] r_addr;
    int         cnt_a, cnt_r;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // One request; mem_wait high for the first wl access cycles.
    task automatic run_req(input logic w, input logic [15:0] a,
                           input logic [7:0] d, input logic [7:0] rd,
                           input int wl);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.mem_rdata = rd;
        bus.mem_wait  = 1'b0;
        r_ram = 0; r_io = 0; r_rom = 0; r_oe = 0; r_we = 0;
        r_wd = '0; r_addr = '0;
        chk($sformatf("ready_%h", a), bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_write = ~w;
        bus.req_addr  = 16'hFFFF;
        bus.req_wdata = 8'hFF;
        r_lat = 1;
        while (!bus.rsp_valid && r_lat < 60) begin
            r_ram += int'(bus.ram_cs);
            r_io  += int'(bus.io_cs);
            r_rom += int'(bus.rom_cs);
            r_oe  += int'(bus.mem_oe);
            r_we  += int'(bus.mem_we);
            if (bus.mem_we) r_wd = bus.mem_wdata;
            if (bus.ram_cs | bus.io_cs | bus.rom_cs) r_addr = bus.mem_addr;
            bus.mem_wait = (r_lat <= wl);
            @(negedge clk);
            r_lat++;
        end
        bus.mem_wait = 1'b0;
        bus.req_write = 1'b0;
        chk($sformatf("rsp_seen_%h", a), bus.rsp_valid, 1);
        r_err   = bus.rsp_err;
        r_rdata = bus.rsp_rdata;
    endtask

    task automatic stream(input logic [15:0] a, input int cycles,
                          input int exp_n, input string tag);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = a;
        cnt_a = 0;
        cnt_r = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.req_valid && bus.req_ready) cnt_a++;
            if (bus.rsp_valid) cnt_r++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk({tag, "_accepts"}, cnt_a, exp_n);
        chk({tag, "_rsps"}, cnt_r, exp_n);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_wait  = 1'b0;

        // Reset state
        #3;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_cs", {bus.ram_cs, bus.io_cs, bus.rom_cs}, 0);
        chk("rst_strobes", {bus.mem_oe, bus.mem_we}, 0);
        chk("rst_addr", bus.mem_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.req_ready, 1);

        // 1. RAM read
        run_req(1'b0, 16'h1234, 8'h00, 8'hA5, 0);
        chk("ram_rd_lat", r_lat, 2);
        chk("ram_rd_cs", r_ram, 1);
        chk("ram_rd_oe", r_oe, 1);
        chk("ram_rd_we", r_we, 0);
        chk("ram_rd_addr", r_addr, 16'h1234);
        chk("ram_rd_data", r_rdata, 8'hA5);
        chk("ram_rd_err", r_err, 0);
        bus.mem_rdata = 8'h11;
        @(negedge clk);
        chk("ram_rd_pulse", bus.rsp_valid, 0);
        chk("ram_rd_hold", bus.rsp_rdata, 8'hA5);

        // 2. RAM write
        run_req(1'b1, 16'h7FFF, 8'h3C, 8'h99, 0);
        chk("ram_wr_lat", r_lat, 2);
        chk("ram_wr_cs", r_ram, 1);
        chk("ram_wr_we", r_we, 1);
        chk("ram_wr_oe", r_oe, 0);
        chk("ram_wr_wdata", r_wd, 8'h3C);
        chk("ram_wr_err", r_err, 0);
        chk("ram_wr_rdata", r_rdata, 0);

        // 3. ROM read, then protected ROM write
        run_req(1'b0, 16'hFFFC, 8'h00, 8'h5A, 0);
        chk("rom_rd_lat", r_lat, 3);
        chk("rom_rd_cs", r_rom, 2);
        chk("rom_rd_oe", r_oe, 2);
        chk("rom_rd_data", r_rdata, 8'h5A);
        run_req(1'b1, 16'hC000, 8'h42, 8'h00, 0);
        chk("rom_wr_lat", r_lat, 1);
        chk("rom_wr_we", r_we, 0);
        chk("rom_wr_cs", r_rom, 0);
        chk("rom_wr_err", r_err, 1);
        chk("rom_wr_rdata", r_rdata, 0);

        // 4. IO read stretched by mem_wait, then timeout
        run_req(1'b0, 16'h8000, 8'h00, 8'h77, 5);
        chk("io_wait_cs", r_io, 6);
        chk("io_wait_lat", r_lat, 7);
        chk("io_wait_data", r_rdata, 8'h77);
        chk("io_wait_err", r_err, 0);
        run_req(1'b0, 16'h8000, 8'h00, 8'h66, 20);
        chk("io_to_err", r_err, 1);
        chk("io_to_data", r_rdata, 0);
        chk("io_to_lat_ok", (r_lat >= 18 && r_lat <= 20), 1);

        // 5. Reset during an IO access
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h9000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_wait  = 1'b1;
        @(negedge clk);
        chk("mid_io_cs", bus.io_cs, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_cs", {bus.ram_cs, bus.io_cs, bus.rom_cs}, 0);
        chk("abort_strobes", {bus.mem_oe, bus.mem_we}, 0);
        chk("abort_ready", bus.req_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.mem_wait = 1'b0;
        #1;
        chk("abort_ready_after", bus.req_ready, 1);
        cnt_r = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid) cnt_r++;
        end
        chk("abort_no_rsp", cnt_r, 0);
        run_req(1'b0, 16'h0042, 8'h00, 8'hC3, 0);
        chk("abort_ram_data", r_rdata, 8'hC3);
        chk("abort_ram_lat", r_lat, 2);

        // 6. Region boundaries and throughput
        run_req(1'b0, 16'h7FFF, 8'h00, 8'h01, 0);
        chk("bnd_7fff", {r_ram[1:0], r_io[1:0], r_rom[1:0]}, 6'b01_00_00);
        run_req(1'b0, 16'h8000, 8'h00, 8'h02, 0);
        chk("bnd_8000", {r_ram[1:0], r_io[1:0], r_rom[1:0]}, 6'b00_11_00);
        run_req(1'b0, 16'hBFFF, 8'h00, 8'h03, 0);
        chk("bnd_bfff", {r_ram[1:0], r_io[1:0], r_rom[1:0]}, 6'b00_11_00);
        run_req(1'b0, 16'hC000, 8'h00, 8'h04, 0);
        chk("bnd_c000", {r_ram[1:0], r_io[1:0], r_rom[1:0]}, 6'b00_00_10);
        run_req(1'b0, 16'hFFFF, 8'h00, 8'h05, 0);
        chk("bnd_ffff", {r_ram[1:0], r_io[1:0], r_rom[1:0]}, 6'b00_00_10);
        stream(16'h0100, 30, 10, "thr_ram");
        stream(16'hE000, 32, 8, "thr_rom");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
